// File: rtl/writeback_stage_if.sv
// Writeback stage handshake/data bundle: upstream instruction, memory response
// and register-file write port.
interface writeback_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = $clog2(XLEN/8)
);
  logic                  wb_valid_i;
  logic                  wb_ready_o;
  logic [XLEN-1:0]       alu_res_i;
  logic [XLEN-1:0]       instr_imm_i;
  logic [XLEN-1:0]       pc_val_i;
  logic [1:0]            rf_wr_data_src_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  rd_wr_en_i;
  logic [1:0]            ld_size_i;
  logic                  ld_unsigned_i;
  logic [OFF_W-1:0]      ld_off_i;
  logic                  mem_rsp_valid_i;
  logic [XLEN-1:0]       mem_rsp_data_i;
  logic                  rf_wr_en_o;
  logic [REG_ADDR_W-1:0] rf_wr_addr_o;
  logic [XLEN-1:0]       rf_wr_data_o;
  logic                  busy_o;

  modport slave (
    input  wb_valid_i, alu_res_i, instr_imm_i, pc_val_i, rf_wr_data_src_i,
           rd_addr_i, rd_wr_en_i, ld_size_i, ld_unsigned_i, ld_off_i,
           mem_rsp_valid_i, mem_rsp_data_i,
    output wb_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, busy_o
  );

  modport master (
    output wb_valid_i, alu_res_i, instr_imm_i, pc_val_i, rf_wr_data_src_i,
           rd_addr_i, rd_wr_en_i, ld_size_i, ld_unsigned_i, ld_off_i,
           mem_rsp_valid_i, mem_rsp_data_i,
    input  wb_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, busy_o
  );
endinterface

// File: rtl/writeback_stage.sv
// RISC-V writeback stage: selects the retiring value (ALU/load/imm/PC link),
// stalls loads until the memory response, and pulses the register-file write.
module writeback_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  writeback_stage_if.slave  bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                state;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_wr_en;
  logic [1:0]            cap_size;
  logic                  cap_uns;
  logic [OFF_W-1:0]      cap_off;

  logic                  accept;
  logic                  is_mem;
  logic [1:0]            ld_size;
  logic                  ld_uns;
  logic [OFF_W-1:0]      ld_off;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       ld_val;
  logic [XLEN-1:0]       wb_data;
  logic                  fill;
  int                    kept;

  assign bus.wb_ready_o = (state == IDLE);
  assign accept         = bus.wb_valid_i && bus.wb_ready_o;
  assign is_mem         = (bus.rf_wr_data_src_i == SRC_MEM);

  // Load format comes straight from upstream on a same-cycle response,
  // otherwise from the fields captured at accept time.
  always_comb begin
    ld_size = cap_size;
    ld_uns  = cap_uns;
    ld_off  = cap_off;
    if (state == IDLE) begin
      ld_size = bus.ld_size_i;
      ld_uns  = bus.ld_unsigned_i;
      ld_off  = bus.ld_off_i;
    end
  end

  // Byte-align, truncate to the access size, then sign/zero extend.
  // A double access on a 32-bit datapath degenerates to a full word.
  always_comb begin
    shifted = bus.mem_rsp_data_i >> {ld_off, 3'b000};
    kept    = XLEN;
    fill    = 1'b0;
    case (ld_size)
      2'd0:    begin kept = 8;  fill = shifted[7];  end
      2'd1:    begin kept = 16; fill = shifted[15]; end
      2'd2:    begin kept = 32; fill = shifted[31]; end
      default: begin kept = XLEN; fill = shifted[XLEN-1]; end
    endcase
    if (ld_uns) fill = 1'b0;
    ld_val = '0;
    for (int i = 0; i < XLEN; i++)
      ld_val[i] = (i < kept) ? shifted[i] : fill;
  end

  // Write-back source select; PC source yields the link address.
  always_comb begin
    case (bus.rf_wr_data_src_i)
      SRC_ALU: wb_data = bus.alu_res_i;
      SRC_MEM: wb_data = ld_val;
      SRC_IMM: wb_data = bus.instr_imm_i;
      default: wb_data = bus.pc_val_i + XLEN'(4);
    endcase
  end

  // Stage FSM with registered register-file outputs; the write strobe
  // defaults low every cycle so it can only ever be a one-cycle pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      bus.rf_wr_en_o   <= 1'b0;
      bus.rf_wr_addr_o <= '0;
      bus.rf_wr_data_o <= '0;
      bus.busy_o       <= 1'b0;
      cap_rd           <= '0;
      cap_wr_en        <= 1'b0;
      cap_size         <= '0;
      cap_uns          <= 1'b0;
      cap_off          <= '0;
    end else begin
      bus.rf_wr_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem || bus.mem_rsp_valid_i) begin
              bus.rf_wr_addr_o <= bus.rd_addr_i;
              bus.rf_wr_data_o <= wb_data;
              bus.rf_wr_en_o   <= bus.rd_wr_en_i && (bus.rd_addr_i != '0);
            end else begin
              cap_rd     <= bus.rd_addr_i;
              cap_wr_en  <= bus.rd_wr_en_i;
              cap_size   <= bus.ld_size_i;
              cap_uns    <= bus.ld_unsigned_i;
              cap_off    <= bus.ld_off_i;
              state      <= WAIT_MEM;
              bus.busy_o <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rsp_valid_i) begin
            bus.rf_wr_addr_o <= cap_rd;
            bus.rf_wr_data_o <= ld_val;
            bus.rf_wr_en_o   <= cap_wr_en && (cap_rd != '0);
            state            <= IDLE;
            bus.busy_o       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: 64-bit and 32-bit instances.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(64)) b64 ();
  writeback_stage_if #(.XLEN(32)) b32 ();

  writeback_stage #(.XLEN(64)) dut64 (.clk(clk), .resetn(resetn), .bus(b64));
  writeback_stage #(.XLEN(32)) dut32 (.clk(clk), .resetn(resetn), .bus(b32));

  typedef struct { logic [4:0] addr; logic [63:0] data; } exp_t;
  exp_t q64[$];
  exp_t q32[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (resetn && b64.rf_wr_en_o) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL wr64_unexpected: got addr=%0d data=%h expected no write",
                 b64.rf_wr_addr_o, b64.rf_wr_data_o);
      end else begin
        exp_t e;
        e = q64.pop_front();
        if (b64.rf_wr_addr_o !== e.addr || b64.rf_wr_data_o !== e.data) begin
          errors++;
          $display("FAIL wr64: got addr=%0d data=%h expected addr=%0d data=%h",
                   b64.rf_wr_addr_o, b64.rf_wr_data_o, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && b32.rf_wr_en_o) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL wr32_unexpected: got addr=%0d data=%h expected no write",
                 b32.rf_wr_addr_o, b32.rf_wr_data_o);
      end else begin
        exp_t e;
        e = q32.pop_front();
        if (b32.rf_wr_addr_o !== e.addr || b32.rf_wr_data_o !== e.data[31:0]) begin
          errors++;
          $display("FAIL wr32: got addr=%0d data=%h expected addr=%0d data=%h",
                   b32.rf_wr_addr_o, b32.rf_wr_data_o, e.addr, e.data[31:0]);
        end
      end
    end
  end

  // One cycle of stimulus on the 64-bit instance; returns at posedge+1.
  task automatic drive64(input logic vld, input logic [1:0] src, input logic [63:0] val,
                         input logic [4:0] rd, input logic wen, input logic [1:0] sz,
                         input logic uns, input logic [2:0] off,
                         input logic rv, input logic [63:0] rd_data);
    b64.wb_valid_i       = vld;
    b64.rf_wr_data_src_i = src;
    b64.alu_res_i        = val;
    b64.instr_imm_i      = val;
    b64.pc_val_i         = val;
    b64.rd_addr_i        = rd;
    b64.rd_wr_en_i       = wen;
    b64.ld_size_i        = sz;
    b64.ld_unsigned_i    = uns;
    b64.ld_off_i         = off;
    b64.mem_rsp_valid_i  = rv;
    b64.mem_rsp_data_i   = rd_data;
    @(posedge clk);
    #1;
    b64.wb_valid_i      = 1'b0;
    b64.mem_rsp_valid_i = 1'b0;
  endtask

  task automatic push64(input logic [4:0] a, input logic [63:0] d);
    exp_t e;
    e.addr = a; e.data = d;
    q64.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(b64.wb_ready_o), 64'd1);
    chk({tag, "_busy"},  64'(b64.busy_o),     64'd0);
    chk({tag, "_wren"},  64'(b64.rf_wr_en_o), 64'd0);
    chk({tag, "_addr"},  64'(b64.rf_wr_addr_o), 64'd0);
    chk({tag, "_data"},  b64.rf_wr_data_o,    64'd0);
  endtask

  initial begin
    b64.wb_valid_i = 0; b64.alu_res_i = 0; b64.instr_imm_i = 0; b64.pc_val_i = 0;
    b64.rf_wr_data_src_i = 0; b64.rd_addr_i = 0; b64.rd_wr_en_i = 0; b64.ld_size_i = 0;
    b64.ld_unsigned_i = 0; b64.ld_off_i = 0; b64.mem_rsp_valid_i = 0; b64.mem_rsp_data_i = 0;
    b32.wb_valid_i = 0; b32.alu_res_i = 0; b32.instr_imm_i = 0; b32.pc_val_i = 0;
    b32.rf_wr_data_src_i = 0; b32.rd_addr_i = 0; b32.rd_wr_en_i = 0; b32.ld_size_i = 0;
    b32.ld_unsigned_i = 0; b32.ld_off_i = 0; b32.mem_rsp_valid_i = 0; b32.mem_rsp_data_i = 0;

    #1 resetn = 1'b0;
    #12;
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // ALU retirement to x5, followed by an idle cycle (pulse must not repeat)
    push64(5'd5, 64'h1234);
    drive64(1, 2'd0, 64'h1234, 5'd5, 1, 0, 0, 0, 0, 0);
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);

    // PC link to x0: no write, data still updates
    drive64(1, 2'd3, 64'h8000_0000, 5'd0, 1, 0, 0, 0, 0, 0);
    chk("pc_x0_wren", 64'(b64.rf_wr_en_o), 64'd0);
    chk("pc_x0_data", b64.rf_wr_data_o, 64'h8000_0004);
    push64(5'd1, 64'h8000_0004);
    drive64(1, 2'd3, 64'h8000_0000, 5'd1, 1, 0, 0, 0, 0, 0);

    // rd_wr_en_i=0 suppresses the write
    drive64(1, 2'd2, 64'h55, 5'd9, 0, 0, 0, 0, 0, 0);
    chk("nowen_wren", 64'(b64.rf_wr_en_o), 64'd0);
    chk("nowen_addr", 64'(b64.rf_wr_addr_o), 64'd9);

    // Same-cycle byte loads, signed then unsigned
    push64(5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    drive64(1, 2'd1, 0, 5'd7, 1, 2'd0, 0, 3'd3, 1, 64'h0000_0000_80FF_0000);
    chk("samecyc_ready", 64'(b64.wb_ready_o), 64'd1);
    push64(5'd8, 64'h80);
    drive64(1, 2'd1, 0, 5'd8, 1, 2'd0, 1, 3'd3, 1, 64'h0000_0000_80FF_0000);
    // Signed half at offset 6
    push64(5'd11, 64'hFFFF_FFFF_FFFF_ABCD);
    drive64(1, 2'd1, 0, 5'd11, 1, 2'd1, 0, 3'd6, 1, 64'hABCD_0000_0000_0000);

    // Back-to-back ALU then IMM
    push64(5'd12, 64'hCAFE);
    push64(5'd13, 64'hFFFF_FFFF_FFFF_F000);
    drive64(1, 2'd0, 64'hCAFE, 5'd12, 1, 0, 0, 0, 0, 0);
    drive64(1, 2'd2, 64'hFFFF_FFFF_FFFF_F000, 5'd13, 1, 0, 0, 0, 0, 0);
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Stalled signed word load; upstream fields change while waiting
    drive64(1, 2'd1, 0, 5'd10, 1, 2'd2, 0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 64'(b64.wb_ready_o), 64'd0);
      chk("stall_busy",  64'(b64.busy_o), 64'd1);
      drive64(0, 2'd0, 0, 5'd3, 1, 2'd0, 1, 3'd3, 0, 0);
    end
    push64(5'd10, 64'hFFFF_FFFF_DEAD_BEEF);
    drive64(0, 2'd0, 0, 5'd3, 1, 2'd0, 1, 3'd3, 1, 64'h0000_0000_DEAD_BEEF);
    chk("stall_done_ready", 64'(b64.wb_ready_o), 64'd1);
    chk("stall_done_busy",  64'(b64.busy_o), 64'd0);
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while waiting aborts the load; a late response is ignored
    drive64(1, 2'd1, 0, 5'd14, 1, 2'd2, 0, 3'd0, 0, 0);
    chk("pre_reset_busy", 64'(b64.busy_o), 64'd1);
    resetn = 1'b0;
    #2;
    check_reset_outputs("midwait");
    resetn = 1'b1;
    @(posedge clk); #1;
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
    chk("late_rsp_ready", 64'(b64.wb_ready_o), 64'd1);
    chk("late_rsp_busy",  64'(b64.busy_o), 64'd0);

    // Spurious response in IDLE
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("spur_ready", 64'(b64.wb_ready_o), 64'd1);
    chk("spur_wren",  64'(b64.rf_wr_en_o), 64'd0);
    drive64(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 32-bit build: double-size load acts as a word, plus a signed byte
    begin
      exp_t e;
      e.addr = 5'd4; e.data = 64'h8000_0001; q32.push_back(e);
      e.addr = 5'd6; e.data = 64'hFFFF_FFF0; q32.push_back(e);
    end
    b32.wb_valid_i = 1; b32.rf_wr_data_src_i = 2'd1; b32.rd_addr_i = 5'd4; b32.rd_wr_en_i = 1;
    b32.ld_size_i = 2'd3; b32.ld_unsigned_i = 0; b32.ld_off_i = 2'd0;
    b32.mem_rsp_valid_i = 1; b32.mem_rsp_data_i = 32'h8000_0001;
    @(posedge clk); #1;
    b32.rd_addr_i = 5'd6; b32.ld_size_i = 2'd0; b32.ld_off_i = 2'd1;
    b32.mem_rsp_data_i = 32'h0000_F000;
    @(posedge clk); #1;
    b32.wb_valid_i = 0; b32.mem_rsp_valid_i = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised writeback stage for the RISC-V pipeline, between the memory stage and the register file. It accepts one retiring instruction per valid/ready handshake and selects the write-back source (ALU, load data, immediate or PC link). Loads are stalled until a variable-latency memory response arrives, then byte-aligned and sign- or zero-extended. It emits a single-cycle register-file write pulse.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64
- REG_ADDR_W, 5, register address width
- OFF_W, $clog2(XLEN/8), load byte-offset width (derived; not overridden)

- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- wb_valid_i  in  1  upstream instruction valid
- wb_ready_o  out  1  stage can accept an instruction
- alu_res_i  in  XLEN  ALU result
- instr_imm_i  in  XLEN  decoded immediate
- pc_val_i  in  XLEN  instruction PC
- rf_wr_data_src_i  in  2  source select: ALU=0, MEM=1, IMM=2, PC=3
- rd_addr_i  in  REG_ADDR_W  destination register
- rd_wr_en_i  in  1  instruction writes rd
- ld_size_i  in  2  0=byte, 1=half, 2=word, 3=double
- ld_unsigned_i  in  1  zero-extend load when 1
- ld_off_i  in  OFF_W  byte offset of load within the data word
- mem_rsp_valid_i  in  1  load data valid, one-cycle pulse
- mem_rsp_data_i  in  XLEN  raw aligned data word
- rf_wr_en_o  out  1  register-file write strobe
- rf_wr_addr_o  out  REG_ADDR_W  write address
- rf_wr_data_o  out  XLEN  write data
- busy_o  out  1  high while waiting for load data

## Operation
- FSM states: IDLE and WAIT_MEM. In IDLE, wb_ready_o=1. In WAIT_MEM, wb_ready_o=0 and busy_o=1.
- Accept occurs when wb_valid_i && wb_ready_o.
  - Non-MEM source: the result is registered to the outputs on the next edge. The state stays IDLE.
  - MEM source: capture rd_addr_i, rd_wr_en_i, ld_size_i, ld_unsigned_i and ld_off_i.
    - If mem_rsp_valid_i is high in the same cycle, write on the next edge and stay IDLE.
    - Otherwise go to WAIT_MEM.
- WAIT_MEM to IDLE: on mem_rsp_valid_i, the extracted load value is registered to the outputs on the same edge.
- Every MEM-source accept waits for its response, even when no rd write results.
- Source values:
  - ALU gives alu_res_i.
  - IMM gives instr_imm_i.
  - PC gives pc_val_i + 4, modulo 2^XLEN (link address).
  - MEM gives the extracted load.
- Load extraction:
  - Shift mem_rsp_data_i right by ld_off_i*8.
  - Keep the low 8, 16, 32 or 64 bits per ld_size_i.
  - Sign-extend from the top kept bit unless ld_unsigned_i is set, in which case zero-extend.
  - When XLEN=32, ld_size_i=3 is treated as word.
- Write suppression: rf_wr_en_o stays 0 for a retirement when rd_wr_en_i=0 or rd_addr_i=0. Address and data outputs still update.
- rf_wr_en_o is a single-cycle pulse per retirement, never held.
- mem_rsp_valid_i in IDLE with no same-cycle MEM accept is ignored. It causes no write and no state change.

## Timing
- Reset values: state=IDLE, rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0, busy_o=0, wb_ready_o=1 (combinational from state).
- Latency for non-MEM sources: 1 cycle from accept to the rf_wr_en_o pulse.
- Latency for MEM sources: 1 cycle from the mem_rsp_valid_i cycle to the rf_wr_en_o pulse.
- Throughput: 1 instruction/cycle for non-MEM or same-cycle-response loads. Back-to-back accepts produce back-to-back pulses.
- wb_ready_o is low from the cycle after a MEM accept without a response until the cycle after the response. Upstream must hold its instruction while wb_ready_o=0.
- Reset asserted during WAIT_MEM aborts the pending load. After reset, a late mem_rsp_valid_i is ignored per the IDLE rule.
- All outputs except wb_ready_o are registered.

## Test plan
- ALU retirement: accept src=ALU, alu_res_i=0x1234, rd=5 -> next cycle rf_wr_en_o=1, addr=5, data=0x1234; pulse one cycle only.
- x0 and PC link: accept src=PC, pc_val_i=0x8000_0000, rd=0 -> rf_wr_en_o=0 with data=0x8000_0004. Repeat with rd=1 -> write 0x8000_0004 to x1.
- Signed byte load, same-cycle response: size=0, off=3, data=0x00000000_80FF_0000 -> write 0xFFFF_FFFF_FFFF_FF80. Repeat with ld_unsigned_i=1 -> write 0x80.
- Stalled load: accept MEM, hold mem_rsp_valid_i low 3 cycles -> wb_ready_o=0 and busy_o=1 for those cycles. Response data 0x0000_0000_DEAD_BEEF with size=2 signed -> write 0xFFFF_FFFF_DEAD_BEEF one cycle later, then ready returns to 1.
- Reset mid-wait: enter WAIT_MEM, pulse resetn low -> all outputs return to reset values. A following mem_rsp_valid_i produces no write.
- Spurious response: mem_rsp_valid_i in IDLE with no accept -> no write, state unchanged; XLEN=32 build, size=3 load -> behaves as word.
